seq_alu: RTL and testbench

- Next-generation ALU: WIDTH-parametrised, registered output, valid/ready handshakes on input and output.
- Keeps the 12 single-cycle operation codes of the current ALU; adds iterative unsigned multiply, divide and remainder on the spare codes 1100–1110.
- Sits between the decode/issue stage and writeback; stalls issue through in_ready while a multi-cycle operation runs.

---
 rtl/alu_pkg.sv | 11 +
 rtl/iter_muldiv.sv | 55 +++++
 rtl/seq_alu.sv | 84 ++++++++
 tb/tb_seq_alu.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, FSM state type and op classification for seq_alu and iter_muldiv
package alu_pkg;
  localparam logic [3:0] OP_ADDU = 4'h0, OP_ADD = 4'h1, OP_AND = 4'h2, OP_OR = 4'h3;
  localparam logic [3:0] OP_NOT = 4'h4, OP_NOR = 4'h5, OP_XOR = 4'h6, OP_NEG = 4'h7;
  localparam logic [3:0] OP_SUBU = 4'h8, OP_SUB = 4'h9, OP_SLTU = 4'hA, OP_SLT = 4'hB;
  localparam logic [3:0] OP_MULU = 4'hC, OP_DIVU = 4'hD, OP_REMU = 4'hE, OP_ZERO = 4'hF;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic logic is_iter(input logic [3:0] op);
    return op == OP_MULU || op == OP_DIVU || op == OP_REMU;
  endfunction
endpackage

// File: rtl/iter_muldiv.sv
// iter_muldiv: one-bit-per-cycle shift-add multiply / restoring divide; ports: clk, rst, start+op/a/b in, done+result/ovf/dz out (valid while done)
module iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 26,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             dz
);
  logic [3:0] op_q;
  logic [WIDTH-1:0] hi, lo, bq, m_hi, m_lo, d_hi, d_lo;
  logic [WIDTH:0] sum, sh;
  logic [CNT_W-1:0] cnt;
  logic mul, ge;
  assign mul = op_q == OP_MULU;
  assign sum = {1'b0, hi} + (lo[0] ? {1'b0, bq} : '0);
  assign m_hi = sum[WIDTH:1];
  assign m_lo = {sum[0], lo[WIDTH-1:1]};
  assign sh = {hi, lo[WIDTH-1]};
  assign ge = sh >= {1'b0, bq};
  assign d_hi = ge ? sh[WIDTH-1:0] - bq : sh[WIDTH-1:0];
  assign d_lo = {lo[WIDTH-2:0], ge};
  assign done = cnt == CNT_W'(1);
  assign result = mul ? m_lo : op_q == OP_DIVU ? d_lo : d_hi;
  assign ovf = mul && |m_hi;
  assign dz = !mul && bq == '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= '0;
      hi <= '0;
      lo <= '0;
      bq <= '0;
      cnt <= '0;
    end else if (start) begin
      op_q <= op;
      hi <= '0;
      lo <= a;
      bq <= b;
      cnt <= CNT_W'(WIDTH);
    end else if (cnt != '0) begin
      hi <= mul ? m_hi : d_hi;
      lo <= mul ? m_lo : d_lo;
      cnt <= cnt - CNT_W'(1);
    end
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with registered result; ports: clk, rst, in_valid/in_ready + ctrl/rs/rt in, out_valid/out_ready + rd/overflow/div_zero out
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 26,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rd,
  output logic             overflow,
  output logic             div_zero
);
  state_t state, nxt;
  logic accept, iter, md_done, md_ovf, md_dz, alu_ovf;
  logic [WIDTH-1:0] md_res, alu_res, add, sub;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign accept = in_valid && in_ready;
  assign iter = is_iter(ctrl);
  assign add = rs + rt;
  assign sub = rs - rt;
  iter_muldiv #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_md (
    .clk(clk), .rst(rst), .start(accept && iter), .op(ctrl), .a(rs), .b(rt),
    .done(md_done), .result(md_res), .ovf(md_ovf), .dz(md_dz)
  );
  always_comb begin
    nxt = state;
    if (state == IDLE && accept) nxt = iter ? BUSY : DONE;
    else if (state == BUSY && md_done) nxt = DONE;
    else if (state == DONE && out_ready) nxt = IDLE;
  end
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ctrl)
      OP_ADDU: alu_res = add;
      OP_ADD: begin
        alu_res = add;
        alu_ovf = rs[WIDTH-1] == rt[WIDTH-1] && add[WIDTH-1] != rs[WIDTH-1];
      end
      OP_AND: alu_res = rs & rt;
      OP_OR: alu_res = rs | rt;
      OP_NOT: alu_res = ~rs;
      OP_NOR: alu_res = ~(rs | rt);
      OP_XOR: alu_res = rs ^ rt;
      OP_NEG: alu_res = -rs;
      OP_SUBU: alu_res = sub;
      OP_SUB: begin
        alu_res = sub;
        alu_ovf = rs[WIDTH-1] != rt[WIDTH-1] && sub[WIDTH-1] != rs[WIDTH-1];
      end
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, rs < rt};
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, $signed(rs) < $signed(rt)};
      default: alu_res = '0;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd <= '0;
      overflow <= 1'b0;
      div_zero <= 1'b0;
    end else if (accept && !iter) begin
      rd <= alu_res;
      overflow <= alu_ovf;
      div_zero <= 1'b0;
    end else if (state == BUSY && md_done) begin
      rd <= md_res;
      overflow <= md_ovf;
      div_zero <= md_dz;
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: random and directed checks of seq_alu against an arithmetic reference model
module tb_seq_alu;
  localparam int W = 26;
  localparam longint M = (64'sd1 <<< W) - 1;
  localparam longint SMIN = -(64'sd1 <<< (W - 1));
  localparam longint SMAX = (64'sd1 <<< (W - 1)) - 1;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, overflow, div_zero;
  logic [3:0] ctrl = '0;
  logic [W-1:0] rs = '0, rt = '0, rd;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ctrl(ctrl),
    .rs(rs), .rt(rt), .out_valid(out_valid), .out_ready(out_ready), .rd(rd),
    .overflow(overflow), .div_zero(div_zero)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h required %0h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [3:0] op, input longint a, input longint b,
                                output longint r, output logic o, output logic z);
    longint sa, sb, p;
    sa = a > SMAX ? a - (M + 1) : a;
    sb = b > SMAX ? b - (M + 1) : b;
    r = 0;
    o = 1'b0;
    z = 1'b0;
    case (op)
      4'd0: r = a + b;
      4'd1: begin r = a + b; o = sa + sb < SMIN || sa + sb > SMAX; end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = ~a;
      4'd5: r = ~(a | b);
      4'd6: r = a ^ b;
      4'd7: r = -a;
      4'd8: r = a - b;
      4'd9: begin r = a - b; o = sa - sb < SMIN || sa - sb > SMAX; end
      4'd10: r = longint'(a < b);
      4'd11: r = longint'(sa < sb);
      4'd12: begin p = a * b; r = p; o = (p >>> W) != 0; end
      4'd13: begin z = b == 0; r = b == 0 ? M : a / b; end
      4'd14: begin z = b == 0; r = b == 0 ? a : a % b; end
      default: r = 0;
    endcase
    r = r & M;
  endfunction
  task automatic run(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    longint er;
    logic eo, ez;
    int lat;
    model(op, longint'(a), longint'(b), er, eo, ez);
    @(negedge clk);
    in_valid = 1'b1;
    ctrl = op;
    rs = a;
    rt = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, " latency"}, lat, (op >= 4'd12 && op <= 4'd14) ? W + 1 : 1);
    check({tag, " rd"}, rd, er);
    check({tag, " overflow"}, overflow, eo);
    check({tag, " div_zero"}, div_zero, ez);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, " back_to_idle"}, {out_valid, in_ready}, 2'b01);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [3:0] op;
    logic [W-1:0] a, b;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset rd", rd, 0);
    check("reset flags", {overflow, div_zero}, 0);
    check("reset in_ready", in_ready, 1);
    run(4'd1, 26'h1FFFFFF, 26'h1, "add_ovf");
    run(4'd0, 26'h1FFFFFF, 26'h1, "addu");
    run(4'd11, 26'h3FFFFFF, 26'h1, "slt_neg");
    run(4'd10, 26'h3FFFFFF, 26'h1, "sltu_big");
    run(4'd11, 26'd5, 26'd5, "slt_eq");
    run(4'd10, 26'd5, 26'd5, "sltu_eq");
    run(4'd12, 26'd3000, 26'd5000, "mulu");
    run(4'd12, 26'h2000000, 26'd4, "mulu_ovf");
    run(4'd13, 26'd100, 26'd7, "divu");
    run(4'd14, 26'd100, 26'd7, "remu");
    run(4'd13, 26'h123, 26'h0, "divu_zero");
    run(4'd14, 26'h123, 26'h0, "remu_zero");
    run(4'd9, 26'h2000000, 26'h1, "sub_ovf");
    @(negedge clk);
    in_valid = 1'b1;
    ctrl = 4'd0;
    rs = 26'd7;
    rt = 26'd8;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      rs = 26'd100;
      rt = 26'd100;
      @(posedge clk);
      #1;
      check("bp rd", rd, 15);
      check("bp handshake", {out_valid, in_ready}, 2'b10);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("bp release", {out_valid, in_ready}, 2'b01);
    check("bp rd kept", rd, 15);
    run(4'd0, 26'd9, 26'd1, "after_bp");
    @(negedge clk);
    in_valid = 1'b1;
    ctrl = 4'd12;
    rs = 26'd3000;
    rt = 26'd5000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    check("rst out_valid", out_valid, 0);
    check("rst rd", rd, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst idle", {out_valid, in_ready}, 2'b01);
    run(4'd0, 26'd2, 26'd3, "addu_after_rst");
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a = W'($urandom);
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = W'($urandom_range(1, 20));
        default: b = W'($urandom);
      endcase
      run(op, a, b, "rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
